hs4_sync_sink: RTL

//   Downstream neighbour of the petrify handshake stage. Accepts 4-phase bundled-data tokens
//   (req/ack, DW-bit data) from the async pipeline into the clk domain.

---
 rtl/hs4_sync_sink_pkg.sv | 21 ++
 rtl/hs4_sync_sink_if.sv | 27 ++
 rtl/hs4_sync_sink_sync_ff.sv | 22 ++
 rtl/hs4_sync_sink.sv | 92 +++++++++
 4 files changed

// File: rtl/hs4_sync_sink_pkg.sv
// hs4_pkg: shared types and defaults for the hs4_sync_sink block.
//   state_t    handshake FSM state encoding (2 bits)
//   DW_DEF     default token data width
//   DEPTH_DEF  default FIFO depth
//   SYNC_DEF   default synchroniser length on req_in
//   CNT_W      width of the accepted-token counter
package hs4_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int DW_DEF    = 3;
    localparam int DEPTH_DEF = 4;
    localparam int SYNC_DEF  = 2;
    localparam int CNT_W     = 8;

endpackage

// File: rtl/hs4_sync_sink_if.sv
// hs4_sync_sink_if: groups the 4-phase input side and valid/ready output side.
//   req_in, data_in   4-phase request and bundled data from the async stage
//   ack_out           4-phase acknowledge back to the async stage
//   out_valid, out_ready, out_data   synchronous token stream
// Modports: slave = the sink itself, master = its environment.
interface hs4_sync_sink_if
    import hs4_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic          req_in;
    logic          ack_out;
    logic [DW-1:0] data_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport slave (
        input  req_in, data_in, out_ready,
        output ack_out, out_valid, out_data
    );

    modport master (
        output req_in, data_in, out_ready,
        input  ack_out, out_valid, out_data
    );
endinterface

// File: rtl/hs4_sync_sink_sync_ff.sv
// sync_ff: N-stage flop chain bringing an asynchronous level into the clk domain.
//   clk    sampling clock
//   rst_n  asynchronous active-low reset, chain clears to 0
//   d      asynchronous input
//   q      synchronised output (last stage)
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [N-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[N-2:0], d};
    end

    assign q = chain[N-1];
endmodule

// File: rtl/hs4_sync_sink.sv
// hs4_sync_sink: accepts 4-phase bundled-data tokens into the clk domain,
// buffers them in a small FIFO and presents them on a valid/ready stream.
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   bus         hs4_sync_sink_if.slave (req_in/ack_out/data_in, out_valid/out_ready/out_data)
//   fifo_count  FIFO occupancy 0..DEPTH
//   token_cnt   tokens accepted since reset, wraps
//
// state   | meaning
// IDLE    | waiting for synchronised req
// CAPTURE | write data_in to FIFO when not full, else hold (ack withheld)
// ACK     | ack_out high, waiting for req to fall
// RELEASE | ack_out low again, one cycle before accepting the next token
module hs4_sync_sink
    import hs4_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int SYNC  = SYNC_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    hs4_sync_sink_if.slave           bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         token_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic          req_s;
    state_t        state, state_nxt;
    logic          ack_q;
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop;

    sync_ff #(.N(SYNC)) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.req_in),
        .q     (req_s)
    );

    // Extra MSB on each pointer distinguishes full from empty.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign pop   = !empty && bus.out_ready;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE:    if (req_s) state_nxt = CAPTURE;
            CAPTURE: if (!full) begin
                         push      = 1'b1;
                         state_nxt = ACK;
                     end
            ACK:     if (!req_s) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ack_out comes straight from its own flop so it cannot glitch on state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ack_q     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            token_cnt <= '0;
        end else begin
            state <= state_nxt;
            ack_q <= (state_nxt == ACK);
            if (push) begin
                wr_ptr    <= wr_ptr + PW'(1);
                token_cnt <= token_cnt + CNT_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: contents are only observed when non-empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.data_in;
    end

    assign bus.ack_out   = ack_q;
    assign bus.out_valid = !empty;
    assign bus.out_data  = mem[rd_ptr[AW-1:0]];
    assign fifo_count    = wr_ptr - rd_ptr;
endmodule
